blk_timing: RTL
===============

# blk_timing

Block-timing generator placed directly upstream of the per-block luma/chroma accumulator. It takes the raw active-video stream (vertical sync, data enable, 24-bit pixel) and re-emits it one cycle later together with the `h_save`/`v_save` strobes that mark block boundaries. It tracks the position inside a frame divided into HBLKS×VBLKS blocks of HP×VP pixels. An optional geometry checker suppresses strobes on frames whose shape does not match the configured grid.

## Interface
- `HBLKS`, 10, blocks per line.
- `VBLKS`, 10, block rows per frame.
- `HP`, 30, pixels per block horizontally.
- `VP`, 30, lines per block vertically.
- `VS_POL`, 1, active level of `vs_i`.

Ports:
- `clk_i`  in  1  pixel clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `vs_i`  in  1  vertical sync, active level `VS_POL`.
- `de_i`  in  1  data enable.
- `data_i`  in  24  pixel {R,G,B}.
- `de_o`  out  1  `de_i` delayed 1 cycle.
- `data_o`  out  24  `data_i` delayed 1 cycle.
- `h_save_o`  out  1  high with `de_o` on the last pixel of every block segment of every line.
- `v_save_o`  out  1  one-cycle pulse closing each block row.
- `locked_o`  out  1  FSM in RUN.
- `err_o`  out  1  geometry error; sticky until next vsync edge.

## Operation
- FSM states:
  - SYNC (reset state): wait for the active edge of `vs_i`.
  - RUN: generate strobes.
  - HOLD: error seen; strobes suppressed; wait for the next vsync edge.
- Vsync active edge from any state: clear all counters and `err_o`, go to RUN.
- Counters:
  - `px_cnt` runs 0..HP-1 and wraps.
  - `hb_cnt` runs 0..HBLKS, saturating at HBLKS.
  - `ln_cnt` runs 0..VP-1 and wraps.
  - `vb_cnt` runs 0..VBLKS, saturating at VBLKS.
  - `lin_len` counts active pixels in the current line.
- In RUN, for each `de_i`=1 cycle:
  - If `px_cnt`==HP-1 and `hb_cnt`<HBLKS, assert `h_save_o` on the next cycle.
  - `px_cnt` wraps, and `hb_cnt` increments on that wrap.
- Falling edge of `de_i` (line end):
  - Reset `px_cnt`, `hb_cnt` and `lin_len`.
  - Advance `ln_cnt`.
  - If `ln_cnt`==VP-1 and `vb_cnt`<VBLKS, pulse `v_save_o` on the cycle after `de_o` falls. That cycle never coincides with `h_save_o`.
  - Then `vb_cnt` increments.
- Exactly HBLKS `h_save_o` pulses per line and exactly VBLKS `v_save_o` pulses per well-formed frame.
- Pixels beyond HBLKS·HP in a line, and lines beyond VBLKS·VP in a frame, produce no strobes. They are still passed through on `de_o`/`data_o`.
- `de_o`/`data_o` are passed through in every state, including SYNC and HOLD.
- Widths:
  - Each counter is `$clog2(max+1)` bits.
  - `lin_len` is `$clog2(HBLKS*HP+2)` bits and saturates at HBLKS·HP+1.

## Timing
- Latency: 1 cycle from inputs to all outputs.
- `h_save_o` and `v_save_o` are each single-cycle pulses.
- Reset values: `de_o`=0, `data_o`=0, `h_save_o`=0, `v_save_o`=0, `locked_o`=0, `err_o`=0. State is SYNC and all counters are 0.
- Vsync edge coincident with `de_i`=1: counters reset first, and that pixel counts as pixel 0 of line 0.
- A `de_i` low→high→low of a single cycle is a 1-pixel line.
- Reset mid-line: outputs drop to 0 immediately (async). After release, the block stays in SYNC until the next vsync edge, so no strobes are emitted for the partial frame.
- A `de_i` rising edge while in SYNC is ignored for counting.

## Configuration
- `BLK_TIMING_CHECK_EN` defined:
  - At each line end, `lin_len`≠HBLKS·HP sets `err_o` and moves the FSM to HOLD.
  - At each vsync edge, a previous frame with a line count ≠VBLKS·VP (only when in RUN) pulses `err_o` for 1 cycle, then the FSM re-enters RUN.
  - In HOLD, `h_save_o` and `v_save_o` are forced to 0 and `locked_o`=0.
- Not defined: no length checks, `err_o` is tied to 0, and the FSM never enters HOLD. Saturation rules alone bound strobe generation.

## Test plan
All scenarios use HBLKS=4, VBLKS=3, HP=5, VP=2 (20×6 active frame).
- Reset, vsync edge, then a 20×6 frame → `h_save_o` high on the cycles after pixels 4, 9, 14, 19 of every line (24 pulses); `v_save_o` after lines 1, 3, 5 (3 pulses); `locked_o`=1.
- Line of 23 pixels with CHECK off → still 4 `h_save_o` pulses; pixels 20–22 appear on `de_o` only.
- Line of 19 pixels with CHECK on → `err_o`=1 at line end; no further strobes; `err_o` clears at the next vsync edge and the next good frame yields 24/3 pulses.
- 8-line frame with CHECK on → exactly 3 `v_save_o` pulses; `err_o` pulses at the next vsync edge.
- Reset asserted mid-line 2 → all outputs 0 within the reset; no strobes until the next vsync edge.
- Vsync edge coincident with `de_i`=1 → that pixel counts as pixel 0; first `h_save_o` follows the 5th pixel.

Source files
------------

// File: rtl/blk_timing.sv
// Block-timing generator: 1-cycle pass-through of the video stream plus h_save/v_save block strobes.
// Optional geometry checker enabled by defining BLK_TIMING_CHECK_EN.
module blk_timing #(
    parameter int HBLKS  = 10,
    parameter int VBLKS  = 10,
    parameter int HP     = 30,
    parameter int VP     = 30,
    parameter bit VS_POL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        vs_i,
    input  logic        de_i,
    input  logic [23:0] data_i,
    output logic        de_o,
    output logic [23:0] data_o,
    output logic        h_save_o,
    output logic        v_save_o,
    output logic        locked_o,
    output logic        err_o
);

    localparam int PX_W  = (HP > 1) ? $clog2(HP) : 1;
    localparam int HB_W  = $clog2(HBLKS + 1);
    localparam int LN_W  = (VP > 1) ? $clog2(VP) : 1;
    localparam int VB_W  = $clog2(VBLKS + 1);
    localparam int LEN_W = $clog2(HBLKS * HP + 2);

    localparam logic [PX_W-1:0]  PX_LAST = PX_W'(HP - 1);
    localparam logic [HB_W-1:0]  HB_MAX  = HB_W'(HBLKS);
    localparam logic [LN_W-1:0]  LN_LAST = LN_W'(VP - 1);
    localparam logic [VB_W-1:0]  VB_MAX  = VB_W'(VBLKS);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(HBLKS * HP + 1);

    typedef enum logic [1:0] {SYNC, RUN, HOLD} state_t;

    state_t            state_q, state_d;
    logic [PX_W-1:0]   px_q, px_d;
    logic [HB_W-1:0]   hb_q, hb_d;
    logic [LN_W-1:0]   ln_q, ln_d;
    logic [VB_W-1:0]   vb_q, vb_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              vs_q;
    logic              h_d, v_d;
    logic              vs_act, vs_edge, line_end;

`ifdef BLK_TIMING_CHECK_EN
    localparam int FR_W = $clog2(VBLKS * VP + 2);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(HBLKS * HP);
    localparam logic [FR_W-1:0]  FR_FULL  = FR_W'(VBLKS * VP);
    localparam logic [FR_W-1:0]  FR_SAT   = FR_W'(VBLKS * VP + 1);
    logic [FR_W-1:0]   fr_q, fr_d;
    logic              err_q, err_d;
`endif

    assign vs_act   = (vs_i == VS_POL);
    assign vs_edge  = vs_act & ~vs_q;
    // de_o holds the previous cycle's de_i, so this marks the falling edge
    assign line_end = de_o & ~de_i;

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        hb_d    = hb_q;
        ln_d    = ln_q;
        vb_d    = vb_q;
        len_d   = len_q;
        h_d     = 1'b0;
        v_d     = 1'b0;
`ifdef BLK_TIMING_CHECK_EN
        fr_d    = fr_q;
        err_d   = err_q & (state_q == HOLD);
`endif
        if (vs_edge) begin
            state_d = RUN;
            px_d    = '0;
            hb_d    = '0;
            ln_d    = '0;
            vb_d    = '0;
            len_d   = '0;
`ifdef BLK_TIMING_CHECK_EN
            fr_d    = '0;
            err_d   = (state_q == RUN) && (fr_q != FR_FULL);
`endif
        end
        // Counting starts from the cleared values when the vsync edge lands on a pixel
        if (vs_edge || state_q == RUN) begin
            if (de_i) begin
                h_d = (px_d == PX_LAST) && (hb_d < HB_MAX) && (vb_d < VB_MAX);
                if (len_d != LEN_SAT) len_d = len_d + 1'b1;
                if (px_d == PX_LAST) begin
                    px_d = '0;
                    if (hb_d != HB_MAX) hb_d = hb_d + 1'b1;
                end else begin
                    px_d = px_d + 1'b1;
                end
            end else if (line_end && !vs_edge) begin
                v_d = (ln_d == LN_LAST) && (vb_d < VB_MAX);
`ifdef BLK_TIMING_CHECK_EN
                if (len_d != LEN_FULL) begin
                    err_d   = 1'b1;
                    state_d = HOLD;
                    v_d     = 1'b0;
                end
                if (fr_d != FR_SAT) fr_d = fr_d + 1'b1;
`endif
                px_d  = '0;
                hb_d  = '0;
                len_d = '0;
                if (ln_d == LN_LAST) begin
                    ln_d = '0;
                    if (vb_d != VB_MAX) vb_d = vb_d + 1'b1;
                end else begin
                    ln_d = ln_d + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= SYNC;
            px_q     <= '0;
            hb_q     <= '0;
            ln_q     <= '0;
            vb_q     <= '0;
            len_q    <= '0;
            vs_q     <= 1'b1;
            de_o     <= 1'b0;
            data_o   <= '0;
            h_save_o <= 1'b0;
            v_save_o <= 1'b0;
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            hb_q     <= hb_d;
            ln_q     <= ln_d;
            vb_q     <= vb_d;
            len_q    <= len_d;
            vs_q     <= vs_act;
            de_o     <= de_i;
            data_o   <= data_i;
            h_save_o <= h_d;
            v_save_o <= v_d;
        end
    end

`ifdef BLK_TIMING_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            fr_q  <= fr_d;
            err_q <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign locked_o = (state_q == RUN);

endmodule
